// File: rtl/branch_target_stage_pkg.sv
// -----------------------------------------------------------------------------
// branch_target_stage_pkg
// Shared definitions for the branch target stage of the 16-bit RISC datapath:
//   DATA_W          width of PC, offset and target
//   CNT_W_DEFAULT   default width of the taken-branch counter
//   state_t         skid-buffer occupancy encoding (EMPTY/BUSY/FULL)
//   entry_t         buffered entry {target, taken, ovf}
//   entry_nowrap_t  same entry without the wrap flag (address-wrap detection
//                   compiled out, see BTS_ADDR_WRAP_EN in the top module)
//   addr_wrap()     address-space wrap detector for target = pc + offset
// -----------------------------------------------------------------------------
package branch_target_stage_pkg;

  localparam int DATA_W        = 16;
  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] target;
    logic              taken;
    logic              ovf;
  } entry_t;

  typedef struct packed {
    logic [DATA_W-1:0] target;
    logic              taken;
  } entry_nowrap_t;

  // A non-negative offset must never produce a smaller address, and a
  // negative one must never produce a larger address; otherwise the add
  // wrapped around the address space.
  function automatic logic addr_wrap(input logic [DATA_W-1:0] pc,
                                     input logic [DATA_W-1:0] off,
                                     input logic [DATA_W-1:0] sum);
    return off[DATA_W-1] ? (sum > pc) : (sum < pc);
  endfunction

endpackage

// File: rtl/branch_target_stage_if.sv
// -----------------------------------------------------------------------------
// branch_target_stage_if
// Bundles both handshake channels of the branch target stage.
//   Input channel : in_valid, in_ready, pc_in, offset_in, br_taken_in
//   Output channel: out_valid, out_ready, target_out, taken_out, ovf_out
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. The producer keeps valid and its payload
// stable until that transfer; ready never depends combinationally on valid.
// Modports:
//   master - producer of pc/offset and consumer of the target (upstream/TB)
//   slave  - the branch target stage itself
// -----------------------------------------------------------------------------
interface branch_target_stage_if;
  import branch_target_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] offset_in;
  logic              br_taken_in;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] target_out;
  logic              taken_out;
  logic              ovf_out;

  modport master (
    output in_valid, pc_in, offset_in, br_taken_in, out_ready,
    input  in_ready, out_valid, target_out, taken_out, ovf_out
  );

  modport slave (
    input  in_valid, pc_in, offset_in, br_taken_in, out_ready,
    output in_ready, out_valid, target_out, taken_out, ovf_out
  );

endinterface

// File: rtl/branch_target_stage_skid_buffer.sv
// -----------------------------------------------------------------------------
// bts_skid_buffer
// Generic 2-entry valid/ready skid register. Both in_ready and out_valid are
// decoded from the state register only, so downstream back-pressure never
// reaches the upstream side combinationally.
// Parameters:
//   T          payload type (packed)
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   flush      synchronous drop of all entries (wins over accept and emit)
//   in_valid / in_ready / in_data     upstream channel
//   out_valid / out_ready / out_data  downstream channel (out_data = main reg)
//   state      current occupancy, for debug
// -----------------------------------------------------------------------------
module bts_skid_buffer
  import branch_target_stage_pkg::*;
#(
  parameter type T = entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   in_valid,
  output logic   in_ready,
  input  T       in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output T       out_data,
  output state_t state
);

  state_t state_q;
  state_t state_d;
  T       main_q;
  T       skid_q;
  logic   accept;
  logic   emit;

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) state_d = BUSY;
        BUSY: begin
          if (accept && !emit)      state_d = FULL;
          else if (!accept && emit) state_d = EMPTY;
        end
        FULL:  if (emit) state_d = BUSY;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output decode (from the registered state only)
  always_comb begin
    in_ready  = (state_q == EMPTY) || (state_q == BUSY);
    out_valid = (state_q == BUSY)  || (state_q == FULL);
  end

  // Data registers. The main register is what the consumer sees, so it only
  // changes on an emit or when it is empty; this keeps the output stable
  // while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      case (state_q)
        EMPTY: if (accept) main_q <= in_data;
        BUSY: begin
          if (accept && emit) main_q <= in_data;
          else if (accept)    skid_q <= in_data;
        end
        FULL:  if (emit) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign out_data = main_q;
  assign state    = state_q;

endmodule

// File: rtl/branch_target_stage.sv
// -----------------------------------------------------------------------------
// branch_target_stage
// Forms target = pc_in + offset_in (mod 2^DATA_W) for branches/jumps and hands
// it to the PC-update logic through a 2-entry skid buffer. Also keeps a
// saturating count of accepted taken branches.
// Build option:
//   BTS_ADDR_WRAP_EN  when defined, ovf_out flags targets that wrapped the
//                     address space and travels with its entry; when not
//                     defined, ovf_out is tied to 0 and no wrap logic exists.
// Parameters:
//   CNT_W      taken-branch counter width (DATA_W comes from the package)
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   flush      synchronous flush: drops buffered entries and same-cycle input
//   bus        slave side of branch_target_stage_if (both handshake channels)
//   taken_cnt  saturating count of accepted taken branches (not flushed)
//   state_dbg  skid-buffer occupancy, for debug
// -----------------------------------------------------------------------------
module branch_target_stage
  import branch_target_stage_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  branch_target_stage_if.slave  bus,
  output logic [CNT_W-1:0]      taken_cnt,
  output state_t                state_dbg
);

`ifdef BTS_ADDR_WRAP_EN
  typedef entry_t payload_t;
`else
  typedef entry_nowrap_t payload_t;
`endif

  logic [DATA_W-1:0] sum;
  payload_t          in_entry;
  payload_t          out_entry;
  logic              accept;

  // Carry out of the add is intentionally discarded.
  assign sum = bus.pc_in + bus.offset_in;

  always_comb begin
    in_entry        = '0;
    in_entry.target = sum;
    in_entry.taken  = bus.br_taken_in;
`ifdef BTS_ADDR_WRAP_EN
    in_entry.ovf    = addr_wrap(bus.pc_in, bus.offset_in, sum);
`endif
  end

  bts_skid_buffer #(
    .T (payload_t)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_entry),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_entry),
    .state     (state_dbg)
  );

  assign bus.target_out = out_entry.target;
  assign bus.taken_out  = out_entry.taken;
`ifdef BTS_ADDR_WRAP_EN
  assign bus.ovf_out    = out_entry.ovf;
`else
  assign bus.ovf_out    = 1'b0;
`endif

  // A flushed input is dropped, so it must not be counted either.
  assign accept = bus.in_valid && bus.in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_cnt <= '0;
    end else if (accept && bus.br_taken_in && (taken_cnt != '1)) begin
      taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule
